msi_cache_ctrl: RTL and testbench

- Per-core MSI cache controller that sits directly upstream of the 64-line direct-mapped line-store.
- Accepts 16-bit CPU word reads/writes, sequences tag lookup, hit return, write merge, dirty-victim writeback, line fill and shared-to-modified upgrade over the shared bus, then installs lines with the correct blk_state_t.
- Snoop response is out of scope; a separate snoop agent handles it.

---
 rtl/msi_cache_ctrl.sv | 251 +++++++++++++++++++++++++
 tb/tb_msi_cache_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msi_cache_ctrl.sv
// Per-core MSI cache controller sequencing CPU word accesses against a
// direct-mapped line-store and the shared bus (writeback, fill, upgrade).
module msi_cache_ctrl #(
  parameter int IDX_W = 6,
  parameter int TAG_W = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_cpu_req,
  input  logic                   i_cpu_wr,
  input  logic [TAG_W+IDX_W+1:0] i_cpu_addr,
  input  logic [15:0]            i_cpu_wdata,
  output logic [15:0]            o_cpu_rdata,
  output logic                   o_cpu_rdy,
  output logic [TAG_W+IDX_W-1:0] o_c_addr,
  output logic                   o_c_re,
  output logic                   o_c_we,
  output logic [63:0]            o_c_wr_data,
  output logic [1:0]             o_c_wstate,
  input  logic                   i_c_hit,
  input  logic                   i_c_dirty,
  input  logic [1:0]             i_c_rstate,
  input  logic [63:0]            i_c_rd_data,
  input  logic [TAG_W-1:0]       i_c_tag,
  output logic                   o_bus_req,
  output logic [1:0]             o_bus_cmd,
  output logic [TAG_W+IDX_W-1:0] o_bus_addr,
  output logic [63:0]            o_bus_wdata,
  input  logic                   i_bus_gnt,
  input  logic                   i_bus_ack,
  input  logic [63:0]            i_bus_rdata,
  input  logic                   i_bus_shared
);

  localparam int LINE_W = TAG_W + IDX_W;
  localparam int ADDR_W = LINE_W + 2;

  localparam logic [1:0] CMD_BUSRD   = 2'd0;
  localparam logic [1:0] CMD_BUSRDX  = 2'd1;
  localparam logic [1:0] CMD_BUSUPGR = 2'd2;
  localparam logic [1:0] CMD_WB      = 2'd3;

  typedef enum logic [1:0] {
    BLK_INVALID   = 2'd0,
    BLK_SHARED    = 2'd1,
    BLK_EXCLUSIVE = 2'd2,
    BLK_MODIFIED  = 2'd3
  } blk_state_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMP,
    S_WB,
    S_WB_GAP,
    S_FILL,
    S_UPGR,
    S_INSTALL
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_wr;
  logic [15:0]         r_wdata;
  logic [63:0]         r_line;
  logic [1:0]          r_wstate;
  logic [LINE_W-1:0]   r_wb_addr;
  logic [63:0]         r_wb_data;
  logic                r_cpu_rdy;
  logic [15:0]         r_cpu_rdata;

  logic [1:0]          w_word_sel;
  logic [IDX_W-1:0]    w_idx;
  logic [LINE_W-1:0]   w_line_addr;
  logic                w_accept;
  logic                w_bus_done;
  logic [63:0]         w_merge_hit;
  logic [63:0]         w_merge_fill;

  function automatic logic [63:0] mergeWord(input logic [63:0] line,
                                            input logic [1:0]  sel,
                                            input logic [15:0] word);
    logic [63:0] merged;
    merged = line;
    merged[{sel, 4'b0000} +: 16] = word;
    return merged;
  endfunction

  function automatic logic [15:0] pickWord(input logic [63:0] line,
                                           input logic [1:0]  sel);
    return line[{sel, 4'b0000} +: 16];
  endfunction

  assign w_word_sel   = r_addr[1:0];
  assign w_idx        = r_addr[IDX_W+1:2];
  assign w_line_addr  = r_addr[ADDR_W-1:2];
  // The completion pulse cycle is spent in IDLE while the CPU still holds its
  // request, so acceptance waits one cycle to avoid replaying the access.
  assign w_accept     = (r_state == S_IDLE) && i_cpu_req && !r_cpu_rdy;
  assign w_bus_done   = i_bus_gnt && i_bus_ack;
  assign w_merge_hit  = mergeWord(i_c_rd_data, w_word_sel, r_wdata);
  assign w_merge_fill = mergeWord(i_bus_rdata, w_word_sel, r_wdata);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    o_c_re     = 1'b0;
    o_c_we     = 1'b0;
    o_c_addr   = w_line_addr;
    o_bus_req  = 1'b0;
    o_bus_cmd  = CMD_BUSRD;
    o_bus_addr = '0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          o_c_re   = 1'b1;
          o_c_addr = i_cpu_addr[ADDR_W-1:2];
          w_next   = S_CMP;
        end
      end
      S_CMP: begin
        o_c_re = 1'b1;
        if (i_c_hit) begin
          if (!r_wr) begin
            w_next = S_IDLE;
          end else if (i_c_rstate == BLK_SHARED) begin
            w_next = S_UPGR;
          end else begin
            w_next = S_INSTALL;
          end
        end else if (i_c_dirty) begin
          w_next = S_WB;
        end else begin
          w_next = S_FILL;
        end
      end
      S_WB: begin
        o_bus_req  = 1'b1;
        o_bus_cmd  = CMD_WB;
        o_bus_addr = r_wb_addr;
        if (w_bus_done) begin
          w_next = S_WB_GAP;
        end
      end
      S_WB_GAP: begin
        w_next = S_FILL;
      end
      S_FILL: begin
        o_bus_req  = 1'b1;
        o_bus_cmd  = r_wr ? CMD_BUSRDX : CMD_BUSRD;
        o_bus_addr = w_line_addr;
        if (w_bus_done) begin
          w_next = S_INSTALL;
        end
      end
      S_UPGR: begin
        o_bus_req  = 1'b1;
        o_bus_cmd  = CMD_BUSUPGR;
        o_bus_addr = w_line_addr;
        if (w_bus_done) begin
          w_next = S_INSTALL;
        end
      end
      S_INSTALL: begin
        o_c_we = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr    <= '0;
      r_wr      <= 1'b0;
      r_wdata   <= '0;
      r_line    <= '0;
      r_wstate  <= BLK_INVALID;
      r_wb_addr <= '0;
      r_wb_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr  <= i_cpu_addr;
            r_wr    <= i_cpu_wr;
            r_wdata <= i_cpu_wdata;
          end
        end
        S_CMP: begin
          if (i_c_hit && r_wr) begin
            r_line   <= w_merge_hit;
            r_wstate <= BLK_MODIFIED;
          end else if (!i_c_hit && i_c_dirty) begin
            r_wb_data <= i_c_rd_data;
            r_wb_addr <= {i_c_tag, w_idx};
          end
        end
        S_FILL: begin
          if (w_bus_done) begin
            if (r_wr) begin
              r_line   <= w_merge_fill;
              r_wstate <= BLK_MODIFIED;
            end else begin
              r_line   <= i_bus_rdata;
              r_wstate <= i_bus_shared ? BLK_SHARED : BLK_EXCLUSIVE;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Completion is registered: read hits answer straight from the lookup data,
  // everything else answers from the line just installed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cpu_rdy   <= 1'b0;
      r_cpu_rdata <= '0;
    end else begin
      r_cpu_rdy <= 1'b0;
      if (r_state == S_CMP && i_c_hit && !r_wr) begin
        r_cpu_rdy   <= 1'b1;
        r_cpu_rdata <= pickWord(i_c_rd_data, w_word_sel);
      end else if (r_state == S_INSTALL) begin
        r_cpu_rdy <= 1'b1;
        if (!r_wr) begin
          r_cpu_rdata <= pickWord(r_line, w_word_sel);
        end
      end
    end
  end

  assign o_cpu_rdy   = r_cpu_rdy;
  assign o_cpu_rdata = r_cpu_rdata;
  assign o_c_wr_data = r_line;
  assign o_c_wstate  = r_wstate;
  assign o_bus_wdata = r_wb_data;

endmodule

// File: tb/tb_msi_cache_ctrl.sv
// Scoreboard bench for msi_cache_ctrl: a line-store and bus responder surround
// the DUT while a cache-level reference model predicts every observable effect.
module tb_msi_cache_ctrl;

  localparam logic [1:0] ST_I = 2'd0, ST_S = 2'd1, ST_E = 2'd2, ST_M = 2'd3;
  localparam logic [1:0] CMD_RD = 2'd0, CMD_RDX = 2'd1, CMD_UPGR = 2'd2, CMD_WB = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpuReq = 1'b0, cpuWr = 1'b0;
  logic [12:0] cpuAddr = '0;
  logic [15:0] cpuWdata = '0;
  logic [15:0] cpuRdata;
  logic        cpuRdy;
  logic [10:0] cAddr;
  logic        cRe, cWe;
  logic [63:0] cWrData;
  logic [1:0]  cWstate;
  logic        cHit = 1'b0, cDirty = 1'b0;
  logic [1:0]  cRstate = '0;
  logic [63:0] cRdData = '0;
  logic [4:0]  cTag = '0;
  logic        busReq;
  logic [1:0]  busCmd;
  logic [10:0] busAddr;
  logic [63:0] busWdata;
  logic        busGnt = 1'b0, busAck = 1'b0;
  logic [63:0] busRdata = '0;
  logic        busShared = 1'b0;
  logic        holdGnt = 1'b0;

  int checks = 0;
  int failures = 0;

  typedef struct packed { logic isRead; logic [15:0] rdata; } rdyExp_t;
  typedef struct packed { logic [1:0] cmd; logic [10:0] addr; logic [63:0] data; logic chkData; } busExp_t;
  typedef struct packed { logic [10:0] addr; logic [63:0] data; logic [1:0] state; } instExp_t;
  typedef struct packed { logic [63:0] data; logic shared; } plan_t;

  rdyExp_t  rdyQ[$];
  busExp_t  busQ[$];
  instExp_t instQ[$];
  plan_t    planQ[$];

  logic [4:0]  lsTag[64]   = '{default: '0};
  logic [1:0]  lsState[64] = '{default: '0};
  logic [63:0] lsData[64]  = '{default: '0};

  logic [4:0]  mTag[64]   = '{default: '0};
  logic [1:0]  mState[64] = '{default: '0};
  logic [63:0] mData[64]  = '{default: '0};

  always #5 clk = ~clk;

  msi_cache_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .i_cpu_req(cpuReq), .i_cpu_wr(cpuWr), .i_cpu_addr(cpuAddr), .i_cpu_wdata(cpuWdata),
    .o_cpu_rdata(cpuRdata), .o_cpu_rdy(cpuRdy),
    .o_c_addr(cAddr), .o_c_re(cRe), .o_c_we(cWe), .o_c_wr_data(cWrData), .o_c_wstate(cWstate),
    .i_c_hit(cHit), .i_c_dirty(cDirty), .i_c_rstate(cRstate), .i_c_rd_data(cRdData), .i_c_tag(cTag),
    .o_bus_req(busReq), .o_bus_cmd(busCmd), .o_bus_addr(busAddr), .o_bus_wdata(busWdata),
    .i_bus_gnt(busGnt), .i_bus_ack(busAck), .i_bus_rdata(busRdata), .i_bus_shared(busShared)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic failNote(input string name, input string actual, input string required);
    checks++;
    failures++;
    $display("[TB] FAIL %s: actual=%s required=%s", name, actual, required);
  endtask

  function automatic logic [63:0] putWord(input logic [63:0] line, input int k, input logic [15:0] w);
    logic [63:0] r;
    r = line;
    r[16*k +: 16] = w;
    return r;
  endfunction

  function automatic logic [15:0] getWord(input logic [63:0] line, input int k);
    return line[16*k +: 16];
  endfunction

  // Synchronous line-store: lookup data appears the cycle after c_re.
  always @(posedge clk) begin
    if (cRe) begin
      cHit    <= (lsState[cAddr[5:0]] != ST_I) && (lsTag[cAddr[5:0]] == cAddr[10:6]);
      cDirty  <= (lsState[cAddr[5:0]] == ST_M);
      cRstate <= lsState[cAddr[5:0]];
      cRdData <= lsData[cAddr[5:0]];
      cTag    <= lsTag[cAddr[5:0]];
    end
    if (cWe) begin
      lsTag[cAddr[5:0]]   <= cAddr[10:6];
      lsState[cAddr[5:0]] <= cWstate;
      lsData[cAddr[5:0]]  <= cWrData;
    end
  end

  // Reference model: cache contents per index plus the MSI rules for one access.
  task automatic modelAccess(input logic [12:0] addr, input logic wr, input logic [15:0] wdata,
                             input logic useFixed, input logic [63:0] fixedData, input logic fixedShared,
                             output int expLat);
    int idx, k;
    logic [4:0] tag;
    logic [10:0] line;
    logic [63:0] d, nd;
    logic sh;
    rdyExp_t r; busExp_t b; instExp_t in; plan_t p;
    idx = int'(addr[7:2]); tag = addr[12:8]; k = int'(addr[1:0]); line = addr[12:2];
    expLat = 0;
    if (mState[idx] != ST_I && mTag[idx] == tag) begin
      if (!wr) begin
        r.isRead = 1'b1; r.rdata = getWord(mData[idx], k); rdyQ.push_back(r);
        expLat = 2;
      end else begin
        nd = putWord(mData[idx], k, wdata);
        if (mState[idx] == ST_S) begin
          b.cmd = CMD_UPGR; b.addr = line; b.data = '0; b.chkData = 1'b0; busQ.push_back(b);
        end else begin
          expLat = 3;
        end
        in.addr = line; in.data = nd; in.state = ST_M; instQ.push_back(in);
        r.isRead = 1'b0; r.rdata = '0; rdyQ.push_back(r);
        mData[idx] = nd; mState[idx] = ST_M;
      end
    end else begin
      if (mState[idx] == ST_M) begin
        b.cmd = CMD_WB; b.addr = {mTag[idx], addr[7:2]}; b.data = mData[idx]; b.chkData = 1'b1;
        busQ.push_back(b);
      end
      d  = useFixed ? fixedData : {$urandom(), $urandom()};
      sh = useFixed ? fixedShared : 1'($urandom_range(0, 1));
      p.data = d; p.shared = sh; planQ.push_back(p);
      b.cmd = wr ? CMD_RDX : CMD_RD; b.addr = line; b.data = '0; b.chkData = 1'b0; busQ.push_back(b);
      nd = wr ? putWord(d, k, wdata) : d;
      in.addr = line; in.data = nd; in.state = wr ? ST_M : (sh ? ST_S : ST_E); instQ.push_back(in);
      r.isRead = !wr; r.rdata = wr ? 16'h0 : getWord(d, k); rdyQ.push_back(r);
      mTag[idx] = tag; mState[idx] = in.state; mData[idx] = nd;
    end
  endtask

  task automatic applyStimulus(input logic [12:0] addr, input logic wr, input logic [15:0] wdata,
                               input logic useFixed, input logic [63:0] fixedData, input logic fixedShared,
                               output logic [15:0] gotData, output int lat);
    int expLat;
    bit done;
    modelAccess(addr, wr, wdata, useFixed, fixedData, fixedShared, expLat);
    @(negedge clk);
    cpuAddr = addr; cpuWr = wr; cpuWdata = wdata; cpuReq = 1'b1;
    lat = 0; done = 0;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
      if (cpuRdy) done = 1;
    end
    gotData = cpuRdata;
    cpuReq = 1'b0;
    if (!done) begin
      failNote("cpu_rdy_timeout", "no_rdy", "rdy_within_200");
      rdyQ.delete(); busQ.delete(); instQ.delete(); planQ.delete();
    end else if (expLat != 0) begin
      checkOutput("hit_latency", 64'(lat), 64'(expLat));
    end
    @(negedge clk);
  endtask

  initial begin : rdyMonitor
    rdyExp_t e;
    logic prevRdy;
    prevRdy = 1'b0;
    forever begin
      @(negedge clk);
      if (cpuRdy) begin
        checkOutput("rdy_not_consecutive", 64'(prevRdy), 64'd0);
        if (rdyQ.size() == 0) begin
          failNote("unexpected_cpu_rdy", "rdy", "none");
        end else begin
          e = rdyQ.pop_front();
          if (e.isRead) checkOutput("cpu_rdata", 64'(cpuRdata), 64'(e.rdata));
        end
      end
      prevRdy = cpuRdy;
    end
  end

  initial begin : installMonitor
    instExp_t e;
    forever begin
      @(negedge clk);
      if (cWe) begin
        checkOutput("c_re_with_c_we", 64'(cRe), 64'd0);
        if (instQ.size() == 0) begin
          failNote("unexpected_install", "c_we", "none");
        end else begin
          e = instQ.pop_front();
          checkOutput("install_addr", 64'(cAddr), 64'(e.addr));
          checkOutput("install_data", cWrData, e.data);
          checkOutput("install_state", 64'(cWstate), 64'(e.state));
        end
      end
    end
  end

  // Bus responder and monitor: random grant delay, stray acks and grants.
  initial begin : busResponder
    int waitCnt;
    plan_t p;
    busExp_t e;
    waitCnt = 0;
    forever begin
      @(negedge clk);
      busGnt = 1'b0;
      busAck = 1'b0;
      if (rst_n && !holdGnt) begin
        if (busReq) begin
          if (waitCnt > 0) begin
            waitCnt--;
            busAck = ($urandom_range(0, 2) == 0);
          end else begin
            busGnt = 1'b1;
            busAck = 1'b1;
            if (busCmd == CMD_RD || busCmd == CMD_RDX) begin
              if (planQ.size() > 0) p = planQ.pop_front();
              else begin p.data = 64'hDEAD_BEEF_DEAD_BEEF; p.shared = 1'b0; end
              busRdata = p.data;
              busShared = p.shared;
            end else begin
              busRdata = {$urandom(), $urandom()};
              busShared = 1'($urandom_range(0, 1));
            end
            if (busQ.size() == 0) begin
              failNote("unexpected_bus_txn", "bus_req", "none");
            end else begin
              e = busQ.pop_front();
              checkOutput("bus_cmd", 64'(busCmd), 64'(e.cmd));
              checkOutput("bus_addr", 64'(busAddr), 64'(e.addr));
              if (e.chkData) checkOutput("bus_wdata", busWdata, e.data);
            end
            waitCnt = $urandom_range(0, 3);
          end
        end else begin
          busGnt = ($urandom_range(0, 3) == 0);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [15:0] got;
    int lat, n;
    logic [1:0] cmd0;
    logic [10:0] a0;
    logic [12:0] ra;
    #12;
    checkOutput("rst_cpu_rdy", 64'(cpuRdy), 64'd0);
    checkOutput("rst_cpu_rdata", 64'(cpuRdata), 64'd0);
    checkOutput("rst_c_re", 64'(cRe), 64'd0);
    checkOutput("rst_c_we", 64'(cWe), 64'd0);
    checkOutput("rst_c_wr_data", cWrData, 64'd0);
    checkOutput("rst_c_wstate", 64'(cWstate), 64'(ST_I));
    checkOutput("rst_bus_req", 64'(busReq), 64'd0);
    checkOutput("rst_bus_cmd", 64'(busCmd), 64'd0);
    checkOutput("rst_bus_addr", 64'(busAddr), 64'd0);
    checkOutput("rst_bus_wdata", busWdata, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(13'h0045, 1'b0, 16'h0, 1'b1, 64'h4444_3333_2222_1111, 1'b0, got, lat);
    checkOutput("tp1_rdata", 64'(got), 64'h2222);
    checkOutput("tp1_state", 64'(lsState[6'h11]), 64'(ST_E));

    applyStimulus(13'h0045, 1'b1, 16'hBEEF, 1'b0, 64'h0, 1'b0, got, lat);
    checkOutput("tp2_latency", 64'(lat), 64'd3);
    checkOutput("tp2_line", lsData[6'h11], 64'h4444_3333_BEEF_1111);
    checkOutput("tp2_state", 64'(lsState[6'h11]), 64'(ST_M));

    applyStimulus(13'h0845, 1'b0, 16'h0, 1'b1, 64'h9999_8888_7777_6666, 1'b1, got, lat);
    checkOutput("tp3_rdata", 64'(got), 64'h7777);
    checkOutput("tp3_state", 64'(lsState[6'h11]), 64'(ST_S));

    applyStimulus(13'h0845, 1'b1, 16'h1234, 1'b0, 64'h0, 1'b0, got, lat);
    checkOutput("tp4_line", lsData[6'h11], 64'h9999_8888_1234_6666);
    checkOutput("tp4_state", 64'(lsState[6'h11]), 64'(ST_M));

    holdGnt = 1'b1;
    fork
      applyStimulus(13'h1C49, 1'b0, 16'h0, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0, got, lat);
      begin
        n = 0;
        while (!busReq && n < 50) begin @(negedge clk); n++; end
        checkOutput("hold_bus_req", 64'(busReq), 64'd1);
        cmd0 = busCmd;
        a0 = busAddr;
        checkOutput("hold_cmd", 64'(cmd0), 64'(CMD_RD));
        checkOutput("hold_addr", 64'(a0), 64'h712);
        repeat (10) begin
          @(negedge clk);
          checkOutput("hold_req_stable", 64'(busReq), 64'd1);
          checkOutput("hold_cmd_stable", 64'(busCmd), 64'(cmd0));
          checkOutput("hold_addr_stable", 64'(busAddr), 64'(a0));
          checkOutput("hold_no_rdy", 64'(cpuRdy), 64'd0);
        end
        holdGnt = 1'b0;
      end
    join
    checkOutput("hold_rdata", 64'(got), 64'hCCCC);

    applyStimulus(13'h1C49, 1'b1, 16'h5555, 1'b0, 64'h0, 1'b0, got, lat);

    // Abandon a writeback with reset; the line must stay dirty for the retry.
    holdGnt = 1'b1;
    @(negedge clk);
    cpuAddr = 13'h0049; cpuWr = 1'b0; cpuReq = 1'b1;
    n = 0;
    while (!busReq && n < 50) begin @(negedge clk); n++; end
    checkOutput("rstwb_cmd", 64'(busCmd), 64'(CMD_WB));
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rstwb_bus_req_async", 64'(busReq), 64'd0);
    checkOutput("rstwb_bus_cmd", 64'(busCmd), 64'd0);
    cpuReq = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    holdGnt = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checkOutput("rstwb_no_rdy", 64'(cpuRdy), 64'd0);
    end
    applyStimulus(13'h0049, 1'b0, 16'h0, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b0, got, lat);
    checkOutput("rstwb_retry_rdata", 64'(got), 64'h89AB);

    for (int i = 0; i < 150; i++) begin
      ra = {5'($urandom_range(0, 3)), 6'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      applyStimulus(ra, 1'($urandom_range(0, 1)), 16'($urandom()), 1'b0, 64'h0, 1'b0, got, lat);
    end

    repeat (5) @(negedge clk);
    checkOutput("rdyQ_drained", 64'(rdyQ.size()), 64'd0);
    checkOutput("busQ_drained", 64'(busQ.size()), 64'd0);
    checkOutput("instQ_drained", 64'(instQ.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
